// File: rtl/mac_acc_array_pkg.sv
// Shared constants for the MAC accumulator array: lane-fusion mode
// encodings and the mapping from mode to group size.
package mac_const;

  typedef enum logic [1:0] {
    MAC_SINGLE = 2'b00,
    MAC_DUAL   = 2'b01,
    MAC_QUAD   = 2'b10
  } mac_mode_e;

  localparam int MAX_GROUP = 4;

  // Number of adjacent lanes fused into one integer; the spare encoding
  // 2'b11 falls back to single lanes.
  function automatic int group_size(input logic [1:0] mode);
    case (mode)
      MAC_DUAL: return 2;
      MAC_QUAD: return MAX_GROUP;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/mac_acc_array_lane.sv
// One accumulator lane: a WIDTH-bit adder with carry in/out feeding a
// loadable accumulator register. What gets loaded (sum, clamp value or
// reload value) is decided by the array top level.
module mac_acc_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, acc} + {1'b0, operand} + {{WIDTH{1'b0}}, carry_in};

  // Accumulator register, updated only when the top level asks for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_value;
    end
  end

endmodule

// File: rtl/mac_acc_array.sv
// Multi-lane multiply-free accumulator array. Adjacent lanes can be fused
// into 2- or 4-lane signed integers; each group accumulates a fixed number
// of beats, optionally saturating, and emits the result with a sticky
// overflow flag on the group's top lane. Pass-through mode forwards input.
module mac_acc_array
  import mac_const::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [1:0]                      cfg_mode,
  input  logic                            cfg_acc,
  input  logic                            cfg_sat,
  input  logic [CNT_WIDTH-1:0]            cfg_len,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] cfg_init,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_ovf
);

  localparam int W = LANE_WIDTH;
  localparam int N = NUM_LANES;
  localparam logic [CNT_WIDTH-1:0] LEN_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           cfg_mode_reg;
  logic                 cfg_acc_reg;
  logic                 cfg_sat_reg;
  logic [CNT_WIDTH-1:0] cfg_len_reg;
  logic [N*W-1:0]       cfg_init_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [N-1:0]         sticky_reg;

  logic [W-1:0]   acc        [N];
  logic [W-1:0]   sum        [N];
  logic [W-1:0]   res        [N];
  logic [W-1:0]   load_value [N];
  logic [N*W-1:0] res_flat;
  logic [N-1:0]   carry_in;
  logic [N-1:0]   carry_out;
  logic [N-1:0]   group_start;
  logic [N-1:0]   group_top;
  logic [N-1:0]   ovf_raw;
  logic [N-1:0]   ovf_lane;
  logic [CNT_WIDTH-1:0] eff_len;
  logic           accept;
  logic           acc_beat;
  logic           last_beat;
  logic           complete;
  logic           lane_load;
  int             group;

  assign in_ready  = !cfg_we && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign acc_beat  = accept && cfg_acc_reg;
  assign eff_len   = (cfg_len_reg == '0) ? LEN_ONE : cfg_len_reg;
  assign last_beat = (count_reg == eff_len - LEN_ONE);
  assign complete  = acc_beat && last_beat;
  assign lane_load = cfg_we || acc_beat;

  // Group geometry: which lanes start a group (carry cut) and which are tops.
  always_comb begin
    group       = group_size(cfg_mode_reg);
    group_start = '0;
    group_top   = '0;
    for (int i = 0; i < N; i++) begin
      group_start[i] = ((i % group) == 0);
      group_top[i]   = (((i + 1) % group) == 0);
    end
  end

  // Carries ripple between lanes of a group but are cut at group starts,
  // so a top lane's carry-out only ever feeds overflow detection.
  assign carry_in = {carry_out[N-2:0], 1'b0} & ~group_start;

  // Signed overflow per lane (carry into MSB differs from carry out of MSB)
  // and the per-lane result after optional clamping to the group limits.
  always_comb begin
    int  top;
    logic s;
    top      = 0;
    s        = 1'b0;
    ovf_raw  = '0;
    for (int i = 0; i < N; i++) begin
      ovf_raw[i] = carry_out[i] ^ (sum[i][W-1] ^ acc[i][W-1] ^ in_data[i*W + W-1]);
    end
    ovf_lane = ovf_raw & group_top;
    for (int i = 0; i < N; i++) begin
      top    = i | (group - 1);
      s      = acc[top][W-1];
      res[i] = sum[i];
      if (cfg_sat_reg && ovf_raw[top]) begin
        res[i] = (i == top) ? {s, {(W-1){~s}}} : {W{~s}};
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mac_acc_lane #(
      .WIDTH(W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (lane_load),
      .load_value(load_value[gi]),
      .operand   (in_data[gi*W +: W]),
      .carry_in  (carry_in[gi]),
      .acc       (acc[gi]),
      .sum       (sum[gi]),
      .carry_out (carry_out[gi])
    );

    // Reconfiguration reloads the new init; a finished window reloads the latched one.
    assign load_value[gi] = cfg_we   ? cfg_init[gi*W +: W]     :
                            complete ? cfg_init_reg[gi*W +: W] : res[gi];
    assign res_flat[gi*W +: W] = res[gi];
  end

  // Configuration, beat counting, sticky overflow and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode_reg <= MAC_SINGLE;
      cfg_acc_reg  <= 1'b0;
      cfg_sat_reg  <= 1'b0;
      cfg_len_reg  <= LEN_ONE;
      cfg_init_reg <= '0;
      count_reg    <= '0;
      sticky_reg   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ovf      <= '0;
    end else if (cfg_we) begin
      cfg_mode_reg <= cfg_mode;
      cfg_acc_reg  <= cfg_acc;
      cfg_sat_reg  <= cfg_sat;
      cfg_len_reg  <= cfg_len;
      cfg_init_reg <= cfg_init;
      count_reg    <= '0;
      sticky_reg   <= '0;
      out_valid    <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (cfg_acc_reg) begin
          if (last_beat) begin
            out_data   <= res_flat;
            out_ovf    <= sticky_reg | ovf_lane;
            out_valid  <= 1'b1;
            count_reg  <= '0;
            sticky_reg <= '0;
          end else begin
            count_reg  <= count_reg + LEN_ONE;
            sticky_reg <= sticky_reg | ovf_lane;
          end
        end else begin
          out_data  <= in_data;
          out_ovf   <= '0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_array.sv
// Directed bench for mac_acc_array (4 lanes x 32 bits) with hand-computed results.
module tb_mac_acc_array;

  localparam int N = 4;
  localparam int W = 32;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [1:0]     cfg_mode;
  logic           cfg_acc;
  logic           cfg_sat;
  logic [C-1:0]   cfg_len;
  logic [N*W-1:0] cfg_init;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mac_acc_array #(
    .NUM_LANES (N),
    .LANE_WIDTH(W),
    .CNT_WIDTH (C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_mode (cfg_mode),
    .cfg_acc  (cfg_acc),
    .cfg_sat  (cfg_sat),
    .cfg_len  (cfg_len),
    .cfg_init (cfg_init),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [1:0] mode, input logic acc, input logic sat,
                           input logic [C-1:0] len, input logic [N*W-1:0] init);
    cfg_mode = mode;
    cfg_acc  = acc;
    cfg_sat  = sat;
    cfg_len  = len;
    cfg_init = init;
    cfg_we   = 1'b1;
    #1;
    check("cfg_blocks_ready", in_ready, 0);
    step();
    cfg_we = 1'b0;
    $display("cfg mode=%0d acc=%0d sat=%0d len=%0d init=%h", mode, acc, sat, len, init);
  endtask

  task automatic send(input logic [N*W-1:0] data);
    in_valid = 1'b1;
    in_data  = data;
    step();
    in_valid = 1'b0;
    $display("beat %h -> out_valid=%0d out_data=%h out_ovf=%b", data, out_valid, out_data, out_ovf);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_mode  = 2'b00;
    cfg_acc   = 1'b0;
    cfg_sat   = 1'b0;
    cfg_len   = '0;
    cfg_init  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    // Single lanes, length 4, two windows back to back
    configure(2'b00, 1'b1, 1'b0, 8'd4, '0);
    send(128'd1);
    send(128'd2);
    send(128'd3);
    check("single_no_early_valid", out_valid, 0);
    send(128'd4);
    check("single_valid", out_valid, 1);
    check("single_sum", out_data, 128'd10);
    send(128'd5);
    check("single_valid_drops", out_valid, 0);
    send(128'd6);
    send(128'd7);
    send(128'd8);
    check("single_second_window", out_data, 128'd26);

    // Single lanes: lane0 carry must not leak into lane1
    configure(2'b00, 1'b1, 1'b0, 8'd2, '0);
    send(128'hFFFF_FFFF);
    send(128'hFFFF_FFFF);
    check("single_no_cross_carry", out_data, 128'hFFFF_FFFE);
    check("single_no_ovf", out_ovf, 0);

    // Quad: carry propagates lane0 -> lane1
    configure(2'b10, 1'b1, 1'b0, 8'd2, '0);
    send(128'hFFFF_FFFF);
    send(128'hFFFF_FFFF);
    check("quad_sum", out_data, 128'h0000_0000_0000_0000_0000_0001_FFFF_FFFE);
    check("quad_ovf", out_ovf, 0);

    // Dual positive overflow, saturate on / off
    configure(2'b01, 1'b1, 1'b1, 8'd1, {64'h0, 64'h7FFF_FFFF_FFFF_FFFF});
    send(128'd1);
    check("dual_sat_pos", out_data, {64'h0, 64'h7FFF_FFFF_FFFF_FFFF});
    check("dual_sat_pos_ovf", out_ovf, 4'b0010);
    configure(2'b01, 1'b1, 1'b0, 8'd1, {64'h0, 64'h7FFF_FFFF_FFFF_FFFF});
    send(128'd1);
    check("dual_wrap", out_data, {64'h0, 64'h8000_0000_0000_0000});
    check("dual_wrap_ovf", out_ovf, 4'b0010);

    // Dual negative overflow clamps to minimum
    configure(2'b01, 1'b1, 1'b1, 8'd1, {64'h0, 64'h8000_0000_0000_0000});
    send({64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    check("dual_sat_neg", out_data, {64'h0, 64'h8000_0000_0000_0000});
    check("dual_sat_neg_ovf", out_ovf, 4'b0010);

    // Sticky overflow survives a clean second beat
    configure(2'b01, 1'b1, 1'b0, 8'd2, {64'h0, 64'h7FFF_FFFF_FFFF_FFFF});
    send(128'd1);
    send(128'd0);
    check("sticky_data", out_data, {64'h0, 64'h8000_0000_0000_0000});
    check("sticky_ovf", out_ovf, 4'b0010);

    // Length 0 behaves as 1, nonzero init
    configure(2'b00, 1'b1, 1'b0, 8'd0, 128'd3);
    send(128'd5);
    check("len0_valid", out_valid, 1);
    check("len0_sum", out_data, 128'd8);

    // Backpressure: result held, input stalled, then resumes
    configure(2'b00, 1'b1, 1'b0, 8'd1, '0);
    out_ready = 1'b0;
    send(128'd7);
    check("bp_first", out_data, 128'd7);
    in_valid = 1'b1;
    in_data  = 128'd9;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready_low", in_ready, 0);
      step();
      check("bp_hold_data", out_data, 128'd7);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_resume_data", out_data, 128'd9);
    check("bp_resume_valid", out_valid, 1);
    step();
    check("bp_drain", out_valid, 0);

    // Pass-through, back to back
    configure(2'b00, 1'b0, 1'b0, 8'd4, '0);
    check("pt_idle", out_valid, 0);
    send(128'hA);
    check("pt_a", out_data, 128'hA);
    check("pt_a_valid", out_valid, 1);
    send(128'hB0000000_0000000B);
    check("pt_b", out_data, 128'hB0000000_0000000B);
    send(128'hC);
    check("pt_c", out_data, 128'hC);
    check("pt_ovf", out_ovf, 0);
    step();
    check("pt_end", out_valid, 0);

    // Reset with a held result
    configure(2'b00, 1'b1, 1'b0, 8'd4, '0);
    out_ready = 1'b0;
    send(128'd1);
    send(128'd2);
    send(128'd3);
    send(128'd4);
    check("rst_held_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_data", out_data, 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    check("rst_release_ready", in_ready, 1);
    step();
    // After reset the block is back in pass-through
    send(128'h55);
    check("rst_cfg_passthrough", out_data, 128'h55);

    // Reset mid-window, then a fresh window
    configure(2'b00, 1'b1, 1'b0, 8'd4, '0);
    send(128'd100);
    send(128'd200);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    #2 rst = 1'b0;
    step();
    configure(2'b00, 1'b1, 1'b0, 8'd4, '0);
    send(128'd1);
    send(128'd2);
    send(128'd3);
    send(128'd4);
    check("rst_fresh_valid", out_valid, 1);
    check("rst_fresh_sum", out_data, 128'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
